// File: rtl/flappy_pkg.sv
// Shared definitions for the pipe-scroll sequencer: one-hot game states,
// score width/ceiling and the score-to-speed-level mapping.
package flappy_pkg;

  localparam int STATE_W = 6;
  localparam int SCORE_W = 4;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 4'd15;

  localparam logic [STATE_W-1:0] S_IDLE     = 6'b000001;
  localparam logic [STATE_W-1:0] S_ARM      = 6'b000010;
  localparam logic [STATE_W-1:0] S_RUN      = 6'b000100;
  localparam logic [STATE_W-1:0] S_STOPPING = 6'b001000;
  localparam logic [STATE_W-1:0] S_OVER     = 6'b010000;
  localparam logic [STATE_W-1:0] S_ACKING   = 6'b100000;

  // Speed level grows one step every level_score points, clamped at max_level.
  function automatic logic [1:0] level_of(input logic [SCORE_W-1:0] score,
                                          input int level_score,
                                          input int max_level);
    int lvl;
    lvl = int'(score) / level_score;
    if (lvl > max_level) lvl = max_level;
    return 2'(lvl);
  endfunction

endpackage

// File: rtl/scroll_divider.sv
// Scroll clock-enable divider: counts 0..period-1 and emits a one-cycle tick.
// The period is captured only on clear or wrap so it never changes mid-count.
module scroll_divider #(
  parameter int DIV_W = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] period,
  output logic             tick,
  output logic             wrap
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic             tick_q, tick_d;

  // Kept as a standalone assign so the period input never appears to feed wrap.
  assign wrap = en && !clr && (cnt_q == period_q - DIV_W'(1));

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    tick_d   = 1'b0;
    if (clr) begin
      cnt_d    = '0;
      period_d = period;
    end else if (en) begin
      if (wrap) begin
        cnt_d    = '0;
        period_d = period;
        tick_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      period_q <= '0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      tick_q   <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/pipe_scroll_ctrl.sv
// Game-level sequencer for the pipe X datapath: Start/Stop/Ack handshake,
// score-dependent scroll speed, game-over hold-off and high-score tracking.
module pipe_scroll_ctrl
  import flappy_pkg::*;
#(
  parameter int TICK_BASE   = 500000,
  parameter int TICK_STEP   = 50000,
  parameter int LEVEL_SCORE = 4,
  parameter int MAX_LEVEL   = 3,
  parameter int OVER_HOLD   = 100000000,
  parameter int DIV_W       = 27
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn,
  input  logic               collision,
  input  logic [SCORE_W-1:0] score,
  input  logic               q_initial,
  input  logic               q_count,
  input  logic               q_stop,
  output logic               scroll_tick,
  output logic               start,
  output logic               stop,
  output logic               ack,
  output logic [1:0]         speed_level,
  output logic [SCORE_W-1:0] high_score,
  output logic [STATE_W-1:0] state
);

  localparam logic [DIV_W-1:0] HOLD_LAST = DIV_W'(OVER_HOLD - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic               start_q, start_d;
  logic               stop_q, stop_d;
  logic               ack_q, ack_d;
  logic [1:0]         speed_q, speed_d;
  logic [SCORE_W-1:0] hs_q, hs_d;
  logic [DIV_W-1:0]   hold_q, hold_d;
  logic               illegal;
  logic               div_en, div_clr, div_wrap, div_tick;
  logic [DIV_W-1:0]   div_period;

  function automatic logic is_counting(input logic [STATE_W-1:0] s);
    return (s == S_ARM) || (s == S_RUN) || (s == S_STOPPING) || (s == S_ACKING);
  endfunction

  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      S_IDLE:     if (btn) state_d = S_ARM;
      S_ARM:      if (q_count) state_d = S_RUN;
      S_RUN:      if (collision || (score == SCORE_MAX)) state_d = S_STOPPING;
      S_STOPPING: if (q_stop) state_d = S_OVER;
      S_OVER:     if (btn && (hold_q == HOLD_LAST)) state_d = S_ACKING;
      S_ACKING:   if (q_initial) state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        illegal = 1'b1;
      end
    endcase
  end

  // The divider runs only while both the current and next state are scrolling
  // states, so no tick can leak into the first OVER or IDLE cycle.
  assign div_en  = is_counting(state_q) && is_counting(state_d);
  assign div_clr = illegal || ((state_d == S_ARM) && (state_q != S_ARM));

  always_comb begin
    speed_d = speed_q;
    if (div_wrap) speed_d = level_of(score, LEVEL_SCORE, MAX_LEVEL);
    if (illegal || ((state_q == S_ACKING) && q_initial)) speed_d = 2'd0;
    div_period = DIV_W'(TICK_BASE - int'(speed_d) * TICK_STEP);

    hold_d = '0;
    if ((state_q == S_OVER) && (state_d == S_OVER))
      hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + DIV_W'(1);

    hs_d = hs_q;
    if ((state_q == S_STOPPING) && q_stop && (score > hs_q)) hs_d = score;

    start_d = (state_d == S_ARM);
    stop_d  = (state_d == S_STOPPING);
    ack_d   = (state_d == S_ACKING);
  end

  scroll_divider #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .en    (div_en),
    .clr   (div_clr),
    .period(div_period),
    .tick  (div_tick),
    .wrap  (div_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      ack_q   <= 1'b0;
      speed_q <= 2'd0;
      hs_q    <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      ack_q   <= ack_d;
      speed_q <= speed_d;
      hs_q    <= hs_d;
      hold_q  <= hold_d;
    end
  end

  assign scroll_tick = div_tick;
  assign start       = start_q;
  assign stop        = stop_q;
  assign ack         = ack_q;
  assign speed_level = speed_q;
  assign high_score  = hs_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pipe_scroll_ctrl.sv
// Bench for pipe_scroll_ctrl: directed game scenarios followed by random play,
// every cycle compared against a game-level reference model.
module tb_pipe_scroll_ctrl;

  localparam int TB_BASE = 10;
  localparam int TB_STEP = 2;
  localparam int TB_LS   = 4;
  localparam int TB_ML   = 3;
  localparam int TB_OH   = 20;

  logic       clk = 1'b0;
  logic       reset, btn, collision, q_initial, q_count, q_stop;
  logic [3:0] score;
  logic       scroll_tick, start, stop, ack;
  logic [1:0] speed_level;
  logic [3:0] high_score;
  logic [5:0] state;

  pipe_scroll_ctrl #(
    .TICK_BASE(TB_BASE), .TICK_STEP(TB_STEP), .LEVEL_SCORE(TB_LS),
    .MAX_LEVEL(TB_ML), .OVER_HOLD(TB_OH), .DIV_W(8)
  ) dut (
    .clk(clk), .reset(reset), .btn(btn), .collision(collision), .score(score),
    .q_initial(q_initial), .q_count(q_count), .q_stop(q_stop),
    .scroll_tick(scroll_tick), .start(start), .stop(stop), .ack(ack),
    .speed_level(speed_level), .high_score(high_score), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  // Reference model: 0 IDLE, 1 ARM, 2 RUN, 3 STOPPING, 4 OVER, 5 ACKING.
  int mst, m_lvl, m_hs, m_remain, m_over_n, cyc_n;
  bit m_tick;

  function automatic bit scrolling(input int s);
    return (s == 1) || (s == 2) || (s == 3) || (s == 5);
  endfunction

  task automatic model_update();
    int ns;
    if (reset) begin
      mst = 0; m_lvl = 0; m_hs = 0; m_remain = 0; m_over_n = 0; m_tick = 0;
    end else begin
      ns = mst;
      case (mst)
        0: if (btn) ns = 1;
        1: if (q_count) ns = 2;
        2: if (collision || score == 4'd15) ns = 3;
        3: if (q_stop) ns = 4;
        4: if (btn && m_over_n >= TB_OH - 1) ns = 5;
        5: if (q_initial) ns = 0;
        default: ns = 0;
      endcase
      m_tick = 0;
      if (ns == 1 && mst != 1) begin
        m_remain = TB_BASE - m_lvl * TB_STEP;
      end else if (scrolling(mst) && scrolling(ns)) begin
        m_remain--;
        if (m_remain == 0) begin
          m_tick = 1;
          m_lvl  = int'(score) / TB_LS;
          if (m_lvl > TB_ML) m_lvl = TB_ML;
          m_remain = TB_BASE - m_lvl * TB_STEP;
        end
      end
      if (mst == 5 && ns == 0) m_lvl = 0;
      if (mst == 3 && ns == 4 && int'(score) > m_hs) m_hs = int'(score);
      m_over_n = (ns == 4 && mst == 4) ? m_over_n + 1 : 0;
      mst = ns;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc_n++;
    check("state", 32'(state), 32'(1 << mst));
    check("start", 32'(start), 32'(mst == 1));
    check("stop", 32'(stop), 32'(mst == 3));
    check("ack", 32'(ack), 32'(mst == 5));
    check("scroll_tick", 32'(scroll_tick), 32'(m_tick));
    check("speed_level", 32'(speed_level), 32'(m_lvl));
    check("high_score", 32'(high_score), 32'(m_hs));
  endtask

  task automatic step();
    model_update();
    advance();
  endtask

  task automatic wait_tick(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      step();
      if (scroll_tick) begin
        at = cyc_n;
        break;
      end
    end
    if (at < 0) check("tick_timeout", 32'(scroll_tick), 32'(1));
  endtask

  task automatic start_game();
    btn = 1; step(); btn = 0;
    q_count = 1; step(); q_count = 0;
  endtask

  task automatic end_game_after_stop();
    q_stop = 1; step(); q_stop = 0;
    btn = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (state == 6'b100000) break;
    end
    btn = 0;
    check("reach_acking", 32'(state), 32'(6'b100000));
    q_initial = 1; step(); q_initial = 0;
    score = 0;
  endtask

  int arm_at, t1, t2, t3, t4, t5, t6;

  initial begin
    cyc_n = 0;
    reset = 1; btn = 0; collision = 0; q_initial = 0; q_count = 0; q_stop = 0; score = 0;
    step(); step();
    check("rst_state", 32'(state), 32'(1));
    check("rst_tick", 32'(scroll_tick), 32'(0));
    reset = 0;

    // Game A: ARM handshake and speed ramp timing
    score = 3;
    btn = 1; step(); btn = 0;
    arm_at = cyc_n;
    check("arm_start", 32'(start), 32'(1));
    step(); step();
    check("arm_held", 32'(state), 32'(6'b000010));
    q_count = 1; step(); q_count = 0;
    check("run_entry", 32'(state), 32'(6'b000100));
    check("run_start_low", 32'(start), 32'(0));
    wait_tick(30, t1); check("first_tick", 32'(t1 - arm_at), 32'(10));
    wait_tick(30, t2); check("period_l0", 32'(t2 - t1), 32'(10));
    score = 4; step();
    wait_tick(30, t3); check("period_latched", 32'(t3 - t2), 32'(10));
    check("level_1", 32'(speed_level), 32'(1));
    wait_tick(30, t4); check("period_l1", 32'(t4 - t3), 32'(8));
    score = 13;
    wait_tick(30, t5); check("period_l1b", 32'(t5 - t4), 32'(8));
    check("level_3", 32'(speed_level), 32'(3));
    wait_tick(30, t6); check("period_l3", 32'(t6 - t5), 32'(4));
    score = 15; step();
    check("sat_stop", 32'(state), 32'(6'b001000));
    step(); step();
    check("stop_held", 32'(stop), 32'(1));
    q_stop = 1; step(); q_stop = 0;
    check("over_entry", 32'(state), 32'(6'b010000));
    check("hs_15", 32'(high_score), 32'(15));
    repeat (5) step();
    btn = 1; step(); btn = 0;
    check("over_btn_early", 32'(state), 32'(6'b010000));
    check("over_no_ack", 32'(ack), 32'(0));
    repeat (12) step();
    btn = 1; step();
    check("over_btn_hold18", 32'(state), 32'(6'b010000));
    step(); btn = 0;
    check("over_btn_accept", 32'(state), 32'(6'b100000));
    step(); step();
    check("ack_held", 32'(ack), 32'(1));
    q_initial = 1; step(); q_initial = 0;
    check("ack_idle", 32'(state), 32'(1));
    check("ack_level0", 32'(speed_level), 32'(0));
    score = 0;
    $display("game A done at cycle %0d", cyc_n);

    // Reset while a stop request is pending
    start_game();
    collision = 1; step(); collision = 0;
    check("pend_stop", 32'(stop), 32'(1));
    reset = 1; step(); reset = 0;
    check("rst_mid_state", 32'(state), 32'(1));
    check("rst_mid_stop", 32'(stop), 32'(0));
    check("rst_mid_hs", 32'(high_score), 32'(0));

    // Game B: collision and btn together, score 6 sets the record
    start_game();
    score = 6; repeat (3) step();
    collision = 1; btn = 1; step(); collision = 0; btn = 0;
    check("col_prio", 32'(state), 32'(6'b001000));
    step(); step();
    end_game_after_stop();
    check("hs_6", 32'(high_score), 32'(6));

    // Game C: equal score leaves the record alone
    start_game();
    score = 6; step();
    collision = 1; step(); collision = 0;
    end_game_after_stop();
    check("hs_equal", 32'(high_score), 32'(6));
    $display("directed games done at cycle %0d", cyc_n);

    // Illegal state recovery
    start_game();
    step();
    force dut.state_q = 6'b000011;
    #1;
    release dut.state_q;
    check("forced", 32'(state), 32'(6'b000011));
    mst = 0; m_lvl = 0; m_over_n = 0; m_tick = 0;
    advance();
    check("illegal_idle", 32'(state), 32'(1));
    check("illegal_hs", 32'(high_score), 32'(6));
    score = 0;

    // Random play
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 599) == 0);
      btn       = ($urandom_range(0, 5) == 0);
      collision = (mst == 2) && ($urandom_range(0, 39) == 0);
      q_count   = (mst == 1) && ($urandom_range(0, 3) == 0);
      q_stop    = (mst == 3) && ($urandom_range(0, 2) == 0);
      q_initial = (mst == 5) && ($urandom_range(0, 2) == 0);
      if (mst == 0) score = 0;
      else if (mst == 2 && score != 4'd15 && $urandom_range(0, 4) == 0) score = score + 4'd1;
      step();
    end
    $display("random play done at cycle %0d", cyc_n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_scroll_ctrl.md
Name: pipe_scroll_ctrl

Overview:
- Game-level sequencer for the moving-pipe X-coordinate datapath.
- Owns the datapath's Start/Stop/Ack handshake and generates the scroll clock-enable that advances pipes 1 px per tick.
- Ramps scroll speed with score and tracks the high score.
- Sits between the debounced flap button, the collision detector and the pipe X datapath.

Parameters:
- TICK_BASE, 500000: clk cycles per scroll step at level 0 (50 MHz -> 100 px/s).
- TICK_STEP, 50000: cycles removed from the period per speed level.
- LEVEL_SCORE, 4: score points per speed level.
- MAX_LEVEL, 3: speed-level ceiling.
- OVER_HOLD, 100000000: minimum cycles in game-over before a restart is accepted.
- DIV_W, 27: divider/hold counter width; must hold max(TICK_BASE, OVER_HOLD).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn  in  1  debounced, single-cycle flap/start pulse
- collision  in  1  bird-pipe/ground hit, level
- score  in  4  datapath score
- q_initial  in  1  datapath in QInitial
- q_count  in  1  datapath in QCount
- q_stop  in  1  datapath in QStop
- scroll_tick  out  1  one-cycle clock-enable for the pipe datapath
- start  out  1  to datapath Start
- stop  out  1  to datapath Stop
- ack  out  1  to datapath Ack
- speed_level  out  2  current level 0..MAX_LEVEL
- high_score  out  4  best score since reset
- state  out  6  one-hot {ACKING,OVER,STOPPING,RUN,ARM,IDLE}

Behaviour:
- One clock domain. Reset is synchronous, active-high; clock port is clk, reset port is reset.
- Reset values: state=IDLE (000001), all handshake outputs 0, scroll_tick 0, speed_level 0, high_score 0, divider and hold counters 0. Reset takes effect mid-game from any state on the next edge.
- Divider:
  - Counts only in ARM, RUN, STOPPING and ACKING.
  - When the counter reaches period-1: scroll_tick=1 for that cycle, counter reloads to 0.
  - period = TICK_BASE - speed_level*TICK_STEP.
  - speed_level = min(score/LEVEL_SCORE, MAX_LEVEL). It is recomputed only on a tick cycle, so the period never changes mid-count.
  - Counter clears to 0 on entry to ARM.
  - First tick occurs period cycles after ARM entry.
- IDLE: all outputs 0 except state. btn -> ARM.
- ARM:
  - start=1 (registered, held).
  - Transition to RUN on the cycle q_count=1; start drops to 0 on that same transition.
- RUN:
  - start=stop=ack=0.
  - collision=1 -> STOPPING. Collision has priority over btn in the same cycle; btn is ignored in RUN.
  - Also exit to STOPPING if score==15 (counter saturation guard).
- STOPPING:
  - stop=1, held.
  - On q_stop=1 -> OVER, with stop=0.
  - On that same edge: high_score <= score if score > high_score (strict). An equal score does not write.
- OVER:
  - scroll_tick suppressed, divider frozen.
  - Hold counter counts up from 0 on entry.
  - btn is ignored until the counter has reached OVER_HOLD-1. After that, btn -> ACKING.
  - The hold counter saturates and does not wrap.
- ACKING:
  - ack=1, held.
  - On q_initial=1 -> IDLE, with ack=0 and speed_level<=0.
- Handshake rule: every request is level-held until the datapath state flag confirms. This tolerates arbitrary tick spacing; no request is a single-cycle pulse.
- Any illegal or non-one-hot state -> IDLE on the next edge, with outputs as at reset except high_score (preserved).
- All outputs are registered. state drives outputs directly (Moore).

Decomposition:
- Shared package flappy_pkg: one-hot state localparams (S_IDLE..S_ACKING), score width 4, SCORE_MAX=15.
- One sub-module, scroll_divider: period input, enable, clear; tick output; period latched on tick.
- FSM, hold counter and high-score register live in pipe_scroll_ctrl.

Test Plan (TICK_BASE=10, TICK_STEP=2, LEVEL_SCORE=4, MAX_LEVEL=3, OVER_HOLD=20, DIV_W=8):
- Reset, pulse btn; datapath model raises q_count 3 cycles later -> state ARM for 3 cycles with start=1, then RUN with start=0; first scroll_tick exactly 10 cycles after ARM entry, then every 10.
- In RUN, score steps 3->4 -> period changes from 10 to 8 only after the next tick; score=13 -> speed_level=3, period 4; score 15 -> STOPPING.
- Collision and btn in the same RUN cycle -> STOPPING, stop=1 until q_stop; score=6 over high_score=0 -> high_score=6. A later game ending at 6 leaves it 6.
- In OVER, btn at hold count 5 -> ignored, no ack, no scroll_tick. btn after 20 cycles -> ACKING, ack=1 until q_initial, then IDLE with speed_level=0.
- Reset asserted in RUN with stop pending -> next edge state=IDLE, all handshakes 0, high_score=0.
- Force state=000011 -> next edge IDLE; high_score unchanged.
